// File: rtl/rf_wb_arb_pkg.sv
// Shared constants, writeback record and entry mapping for the writeback arbiter.
package rf_wb_arb_pkg;

  localparam int unsigned RF_ENTRIES    = 24;
  localparam int unsigned RF_BANK1_BASE = 16;
  localparam int unsigned ENTRY_W       = $clog2(RF_ENTRIES);

  typedef logic [ENTRY_W-1:0] entry_t;

  typedef struct packed {
    logic [3:0]  dst;
    logic        bank;
    logic [31:0] data;
  } wb_rec_t;

  // Bank 1 only shadows R0-R7; R8-R15 ignore the bank bit.
  function automatic entry_t entry_idx(input logic [3:0] dst, input logic bank);
    if (!dst[3] && bank) return ENTRY_W'(RF_BANK1_BASE) | ENTRY_W'(dst[2:0]);
    else                 return ENTRY_W'(dst);
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous load-return FIFO; head is read from storage, so no fall-through.
module rf_wb_fifo
  import rf_wb_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  wb_rec_t din,
  output wb_rec_t head,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  wb_rec_t     mem [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rf_wb_arb.sv
// Register-file writeback arbiter: pipe passthrough, load-return draining,
// pending/kill scoreboard and starvation stall request.
module rf_wb_arb
  import rf_wb_arb_pkg::*;
#(
  parameter int unsigned LD_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_wen,
  input  logic [3:0]  p0_wdst,
  input  logic        p0_wbank,
  input  logic [31:0] p0_wdata,
  input  logic        p1_wen,
  input  logic [3:0]  p1_wdst,
  input  logic        p1_wbank,
  input  logic [31:0] p1_wdata,
  input  logic        ld_issue,
  input  logic [3:0]  ld_issue_dst,
  input  logic        ld_issue_bank,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [3:0]  ld_wdst,
  input  logic        ld_wbank,
  input  logic [31:0] ld_wdata,
  output logic        rf_wen0,
  output logic [3:0]  rf_wdst0,
  output logic        rf_wbank0,
  output logic [31:0] rf_wdata0,
  output logic        rf_wen1,
  output logic [3:0]  rf_wdst1,
  output logic        rf_wbank1,
  output logic [31:0] rf_wdata1,
  output logic [23:0] pend_mask,
  output logic        stall_req
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  wb_rec_t head;
  logic    full, empty, drain, discard, load_wr, hit0, hit1;
  entry_t  e0, e1, ei, he;

  logic [RF_ENTRIES-1:0] pend, pend_n, kill, kill_n;
  logic [CW-1:0]         starve_cnt, cnt_n;

  rf_wb_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ld_valid),
    .pop   (drain),
    .din   ('{dst: ld_wdst, bank: ld_wbank, data: ld_wdata}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign ld_ready  = !full;
  assign pend_mask = pend;

  assign e0   = entry_idx(p0_wdst, p0_wbank);
  assign e1   = entry_idx(p1_wdst, p1_wbank);
  assign ei   = entry_idx(ld_issue_dst, ld_issue_bank);
  assign he   = entry_idx(head.dst, head.bank);
  assign hit0 = p0_wen && pend[e0];
  assign hit1 = p1_wen && pend[e1];

  // A pipe write landing on the head entry in the drain cycle is younger than the
  // load, so it must kill it now rather than let the stale data win on port 1.
  assign drain   = !rst && !empty && (!p1_wen || !p0_wen);
  assign discard = kill[he] || (hit0 && e0 == he) || (hit1 && e1 == he);
  assign load_wr = drain && !discard;

  always_comb begin
    rf_wen0   = p0_wen;
    rf_wdst0  = p0_wdst;
    rf_wbank0 = p0_wbank;
    rf_wdata0 = p0_wdata;
    rf_wen1   = p1_wen;
    rf_wdst1  = p1_wdst;
    rf_wbank1 = p1_wbank;
    rf_wdata1 = p1_wdata;
    if (load_wr && !p1_wen) begin
      rf_wen1   = 1'b1;
      rf_wdst1  = head.dst;
      rf_wbank1 = head.bank;
      rf_wdata1 = head.data;
    end else if (load_wr) begin
      rf_wen0   = 1'b1;
      rf_wdst0  = head.dst;
      rf_wbank0 = head.bank;
      rf_wdata0 = head.data;
    end
  end

  // Ordering gives issue priority over drain, and drain over pipe kills.
  always_comb begin
    pend_n = pend;
    kill_n = kill;
    if (hit0) kill_n[e0] = 1'b1;
    if (hit1) kill_n[e1] = 1'b1;
    if (drain) begin
      pend_n[he] = 1'b0;
      kill_n[he] = 1'b0;
    end
    if (ld_issue) begin
      pend_n[ei] = 1'b1;
      kill_n[ei] = 1'b0;
    end
  end

  always_comb begin
    cnt_n = starve_cnt;
    if (drain)                            cnt_n = '0;
    else if (full && starve_cnt != LIMIT) cnt_n = starve_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= '0;
      kill       <= '0;
      starve_cnt <= '0;
      stall_req  <= 1'b0;
    end else begin
      pend       <= pend_n;
      kill       <= kill_n;
      starve_cnt <= cnt_n;
      stall_req  <= (cnt_n >= LIMIT);
    end
  end

endmodule

// File: tb/tb_rf_wb_arb.sv
// Bench for rf_wb_arb: directed scenarios plus randomized traffic against a queue model.
module tb_rf_wb_arb;

  localparam int LD_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_wen, p0_wbank, p1_wen, p1_wbank;
  logic [3:0]  p0_wdst, p1_wdst;
  logic [31:0] p0_wdata, p1_wdata;
  logic        ld_issue, ld_issue_bank, ld_valid, ld_ready, ld_wbank;
  logic [3:0]  ld_issue_dst, ld_wdst;
  logic [31:0] ld_wdata;
  logic        rf_wen0, rf_wbank0, rf_wen1, rf_wbank1;
  logic [3:0]  rf_wdst0, rf_wdst1;
  logic [31:0] rf_wdata0, rf_wdata1;
  logic [23:0] pend_mask;
  logic        stall_req;

  rf_wb_arb #(.LD_DEPTH(LD_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .p0_wen(p0_wen), .p0_wdst(p0_wdst), .p0_wbank(p0_wbank), .p0_wdata(p0_wdata),
    .p1_wen(p1_wen), .p1_wdst(p1_wdst), .p1_wbank(p1_wbank), .p1_wdata(p1_wdata),
    .ld_issue(ld_issue), .ld_issue_dst(ld_issue_dst), .ld_issue_bank(ld_issue_bank),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_wdst(ld_wdst), .ld_wbank(ld_wbank), .ld_wdata(ld_wdata),
    .rf_wen0(rf_wen0), .rf_wdst0(rf_wdst0), .rf_wbank0(rf_wbank0), .rf_wdata0(rf_wdata0),
    .rf_wen1(rf_wen1), .rf_wdst1(rf_wdst1), .rf_wbank1(rf_wbank1), .rf_wdata1(rf_wdata1),
    .pend_mask(pend_mask), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  dst;
    logic        bank;
    logic [31:0] data;
  } rec_t;

  int    n_chk = 0;
  int    n_err = 0;
  bit    chk_en = 0;
  rec_t  mq[$];
  rec_t  outstanding[$];
  logic [23:0] m_pend = '0;
  logic [23:0] m_kill = '0;
  int    m_cnt = 0;
  bit    m_stall = 0;

  function automatic int ent(input logic [3:0] d, input logic b);
    return (d < 8 && b) ? 16 + int'(d) : int'(d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advances on each edge from the inputs held during that cycle.
  task automatic model_step();
    bit   full_b, drn;
    rec_t h;
    if (rst) begin
      mq.delete();
      m_pend = '0; m_kill = '0; m_cnt = 0; m_stall = 0;
      return;
    end
    full_b = (mq.size() == LD_DEPTH);
    drn    = (mq.size() > 0) && (!p1_wen || !p0_wen);
    if (p0_wen && m_pend[ent(p0_wdst, p0_wbank)]) m_kill[ent(p0_wdst, p0_wbank)] = 1'b1;
    if (p1_wen && m_pend[ent(p1_wdst, p1_wbank)]) m_kill[ent(p1_wdst, p1_wbank)] = 1'b1;
    if (drn) begin
      h = mq.pop_front();
      m_pend[ent(h.dst, h.bank)] = 1'b0;
      m_kill[ent(h.dst, h.bank)] = 1'b0;
    end
    if (ld_valid && !full_b) mq.push_back('{ld_wdst, ld_wbank, ld_wdata});
    if (ld_issue) begin
      m_pend[ent(ld_issue_dst, ld_issue_bank)] = 1'b1;
      m_kill[ent(ld_issue_dst, ld_issue_bank)] = 1'b0;
    end
    if (drn) m_cnt = 0;
    else if (full_b && m_cnt < STARVE_LIMIT) m_cnt = m_cnt + 1;
    m_stall = (m_cnt >= STARVE_LIMIT);
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      rec_t x0, x1, h;
      bit   w0, w1, killed;
      int   he;
      w0 = p0_wen; x0 = '{p0_wdst, p0_wbank, p0_wdata};
      w1 = p1_wen; x1 = '{p1_wdst, p1_wbank, p1_wdata};
      if (!rst && mq.size() > 0 && (!p0_wen || !p1_wen)) begin
        h  = mq[0];
        he = ent(h.dst, h.bank);
        killed = m_kill[he]
              || (p0_wen && m_pend[he] && ent(p0_wdst, p0_wbank) == he)
              || (p1_wen && m_pend[he] && ent(p1_wdst, p1_wbank) == he);
        if (!killed) begin
          if (!p1_wen) begin w1 = 1; x1 = h; end
          else         begin w0 = 1; x0 = h; end
        end
      end
      check("m_wen0", 32'(rf_wen0), 32'(w0));
      if (w0) begin
        check("m_dst0", 32'(rf_wdst0), 32'(x0.dst));
        check("m_bank0", 32'(rf_wbank0), 32'(x0.bank));
        check("m_data0", rf_wdata0, x0.data);
      end
      check("m_wen1", 32'(rf_wen1), 32'(w1));
      if (w1) begin
        check("m_dst1", 32'(rf_wdst1), 32'(x1.dst));
        check("m_bank1", 32'(rf_wbank1), 32'(x1.bank));
        check("m_data1", rf_wdata1, x1.data);
      end
      check("m_ld_ready", 32'(ld_ready), 32'(mq.size() < LD_DEPTH));
      check("m_pend_mask", 32'(pend_mask), 32'(m_pend));
      check("m_stall_req", 32'(stall_req), 32'(m_stall));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0;
    p0_wen = 0; p0_wdst = '0; p0_wbank = 0; p0_wdata = '0;
    p1_wen = 0; p1_wdst = '0; p1_wbank = 0; p1_wdata = '0;
    ld_issue = 0; ld_issue_dst = '0; ld_issue_bank = 0;
    ld_valid = 0; ld_wdst = '0; ld_wbank = 0; ld_wdata = '0;
  endtask

  task automatic pipes_busy();
    p0_wen = 1; p0_wdst = 4'd0; p0_wbank = 0; p0_wdata = 32'hA0;
    p1_wen = 1; p1_wdst = 4'd1; p1_wbank = 0; p1_wdata = 32'hA1;
  endtask

  task automatic issue(input logic [3:0] d, input logic b);
    ld_issue = 1; ld_issue_dst = d; ld_issue_bank = b;
  endtask

  task automatic ret(input logic [3:0] d, input logic b, input logic [31:0] v);
    ld_valid = 1; ld_wdst = d; ld_wbank = b; ld_wdata = v;
  endtask

  initial begin
    idle();
    rst = 1;
    cyc();
    chk_en = 1;
    #3;
    check("rst_ld_ready", 32'(ld_ready), 1);
    check("rst_pend", 32'(pend_mask), 0);
    check("rst_stall", 32'(stall_req), 0);

    // Pipe passthrough
    cyc(); idle();
    p0_wen = 1; p0_wdst = 4'd3; p0_wdata = 32'h11;
    p1_wen = 1; p1_wdst = 4'd4; p1_wdata = 32'h22;
    #3;
    check("pt_wen0", 32'(rf_wen0), 1);
    check("pt_dst0", 32'(rf_wdst0), 3);
    check("pt_data0", rf_wdata0, 32'h11);
    check("pt_wen1", 32'(rf_wen1), 1);
    check("pt_dst1", 32'(rf_wdst1), 4);
    check("pt_data1", rf_wdata1, 32'h22);
    check("pt_pend", 32'(pend_mask), 0);

    // Drain into idle port 1
    cyc(); idle(); issue(4'd8, 0);
    cyc(); idle(); #3 check("dr_pend8_set", 32'(pend_mask[8]), 1);
    cyc(); idle(); ret(4'd8, 0, 32'hDEAD);
    #3 check("dr_no_fallthru", 32'(rf_wen1), 0);
    cyc(); idle();
    #3;
    check("dr_wen1", 32'(rf_wen1), 1);
    check("dr_dst1", 32'(rf_wdst1), 8);
    check("dr_data1", rf_wdata1, 32'hDEAD);
    check("dr_pend8_hold", 32'(pend_mask[8]), 1);
    cyc(); idle(); #3 check("dr_pend8_clr", 32'(pend_mask[8]), 0);

    // Bank-1 entry waits for a free slot
    cyc(); idle(); issue(4'd2, 1);
    cyc(); idle(); #3 check("bk_pend18", 32'(pend_mask), 32'h40000);
    cyc(); idle(); p0_wen = 1; p0_wdata = 32'h1; ret(4'd2, 1, 32'hBEEF);
    cyc(); idle(); pipes_busy();
    #3;
    check("bk_busy_data0", rf_wdata0, 32'hA0);
    check("bk_busy_data1", rf_wdata1, 32'hA1);
    check("bk_busy_pend18", 32'(pend_mask[18]), 1);
    cyc(); idle(); p0_wen = 1; p0_wdata = 32'h2;
    #3;
    check("bk_wen1", 32'(rf_wen1), 1);
    check("bk_dst1", 32'(rf_wdst1), 2);
    check("bk_bank1", 32'(rf_wbank1), 1);
    check("bk_data1", rf_wdata1, 32'hBEEF);
    cyc(); idle(); #3 check("bk_pend18_clr", 32'(pend_mask[18]), 0);

    // WAW kill
    cyc(); idle(); issue(4'd5, 0);
    cyc(); idle(); p0_wen = 1; p0_wdst = 4'd5; p0_wdata = 32'h7;
    #3 check("waw_p0_data", rf_wdata0, 32'h7);
    cyc(); idle(); ret(4'd5, 0, 32'h9);
    cyc(); idle();
    #3;
    check("waw_no_wen0", 32'(rf_wen0), 0);
    check("waw_no_wen1", 32'(rf_wen1), 0);
    cyc(); idle(); #3 check("waw_pend5_clr", 32'(pend_mask[5]), 0);

    // Starvation with a full FIFO
    cyc(); idle(); issue(4'd8, 0);
    cyc(); idle(); issue(4'd9, 0);
    cyc(); idle(); pipes_busy(); ret(4'd8, 0, 32'h100);
    cyc(); idle(); pipes_busy(); ret(4'd9, 0, 32'h101);
    for (int i = 1; i <= 4; i++) begin
      cyc(); idle(); pipes_busy();
      #3;
      check($sformatf("st_c%0d_stall", i), 32'(stall_req), 0);
      check($sformatf("st_c%0d_ready", i), 32'(ld_ready), 0);
    end
    cyc(); idle(); pipes_busy(); ret(4'd12, 0, 32'hBAD);
    #3;
    check("st_c5_stall", 32'(stall_req), 1);
    check("st_c5_ready", 32'(ld_ready), 0);
    cyc(); idle(); pipes_busy(); p1_wen = 0;
    #3;
    check("st_c6_wen1", 32'(rf_wen1), 1);
    check("st_c6_data1", rf_wdata1, 32'h100);
    check("st_c6_stall", 32'(stall_req), 1);
    cyc(); idle();
    #3;
    check("st_c7_stall", 32'(stall_req), 0);
    check("st_c7_data1", rf_wdata1, 32'h101);
    cyc(); idle();
    #3;
    check("st_drop_wen0", 32'(rf_wen0), 0);
    check("st_drop_wen1", 32'(rf_wen1), 0);
    check("st_pend", 32'(pend_mask), 0);

    // Reset discards buffered loads
    cyc(); idle(); issue(4'd10, 0);
    cyc(); idle(); issue(4'd11, 0);
    cyc(); idle(); pipes_busy(); ret(4'd10, 0, 32'h10A);
    cyc(); idle(); pipes_busy(); ret(4'd11, 0, 32'h10B);
    cyc(); idle(); pipes_busy(); #3 check("rs_full", 32'(ld_ready), 0);
    cyc(); idle(); rst = 1;
    #3;
    check("rs_cyc_wen0", 32'(rf_wen0), 0);
    check("rs_cyc_wen1", 32'(rf_wen1), 0);
    cyc(); idle();
    #3;
    check("rs_ready", 32'(ld_ready), 1);
    check("rs_pend", 32'(pend_mask), 0);
    check("rs_wen0", 32'(rf_wen0), 0);
    check("rs_wen1", 32'(rf_wen1), 0);
    cyc(); idle();
    #3 check("rs_wen1_after", 32'(rf_wen1), 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(); idle();
      if ($urandom_range(399) == 0) begin
        rst = 1;
        outstanding.delete();
      end
      p0_wen = $urandom_range(1); p0_wdst = 4'($urandom); p0_wbank = 1'($urandom); p0_wdata = $urandom;
      p1_wen = $urandom_range(1); p1_wdst = 4'($urandom); p1_wbank = 1'($urandom); p1_wdata = $urandom;
      if (!rst && outstanding.size() > 0 && mq.size() < LD_DEPTH && $urandom_range(1) == 1) begin
        int   k;
        rec_t r;
        k = $urandom_range(outstanding.size() - 1);
        r = outstanding[k];
        outstanding.delete(k);
        ret(r.dst, r.bank, $urandom);
      end
      if (!rst && $urandom_range(2) == 0) begin
        logic [3:0] d;
        logic       b;
        d = 4'($urandom); b = 1'($urandom);
        if (!m_pend[ent(d, b)]) begin
          issue(d, b);
          outstanding.push_back('{d, b, 32'h0});
        end
      end
    end
    cyc(); idle();
    cyc();
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_arb.md
Name: rf_wb_arb

Overview:
- Writeback arbiter and load scoreboard in front of the CPU register file's two write ports (rf_wen0/rf_wen1 groups).
- Pipe 0 and pipe 1 results pass straight through. Late load returns are buffered and drained into idle write-port slots.
- A per-entry pending mask lets decode stall on load-use hazards.
- Stale load data is discarded after a younger pipe write to the same register (WAW kill).

Parameters:
LD_DEPTH, 2, load-return FIFO entries (power of two, ≥2)
STARVE_LIMIT, 4, consecutive cycles with FIFO full and no drain before stall_req asserts

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
p0_wen  in  1  pipe-0 writeback valid
p0_wdst  in  4  pipe-0 register index
p0_wbank  in  1  pipe-0 bank select (R0–R7 only)
p0_wdata  in  32  pipe-0 data
p1_wen/p1_wdst/p1_wbank/p1_wdata  in  1/4/1/32  pipe-1 writeback, same meaning; younger than pipe 0 in program order
ld_issue  in  1  load issued; marks its destination pending
ld_issue_dst  in  4  destination of issued load
ld_issue_bank  in  1  bank of issued load
ld_valid  in  1  load data return valid
ld_ready  out  1  FIFO can accept; equals !full
ld_wdst  in  4  return destination
ld_wbank  in  1  return bank
ld_wdata  in  32  return data
rf_wen0/rf_wdst0/rf_wbank0/rf_wdata0  out  1/4/1/32  write port 0
rf_wen1/rf_wdst1/rf_wbank1/rf_wdata1  out  1/4/1/32  write port 1
pend_mask  out  24  pending loads: [15:0] bank-0 R0–R15, [23:16] bank-1 R0–R7
stall_req  out  1  request pipeline hold to let loads drain

Behaviour:
- Entry mapping (used everywhere): e = (!dst[3] && bank) ? 16+dst[2:0] : dst.
- Port drive (combinational):
  - Port 0 carries p0 when p0_wen.
  - Port 1 carries p1 when p1_wen.
  - The FIFO head drains into port 1 if !p1_wen, else into port 0 if !p0_wen, else waits.
  - At most one drain per cycle.
- Equal p0/p1 destinations in the same cycle are both driven. The register file gives port 1 precedence, which is correct because p1 is younger.
- FIFO:
  - Push when ld_valid && ld_ready.
  - A push at cycle N is drainable no earlier than N+1; there is no fall-through.
  - Push and drain in the same cycle are both legal when not full.
  - ld_valid while !ld_ready is a protocol error; the data is dropped and never written.
- Scoreboard and kill:
  - ld_issue sets pend[e] and clears kill[e] at the next edge.
  - A pipe write whose e has pend set also sets kill[e].
  - On drain: if kill[e], rf_wen is NOT asserted (slot consumed, data discarded). Either way pend[e] and kill[e] clear.
  - Same-cycle issue and drain of one e: the issue wins, so pend stays 1 and kill ends 0.
  - At most one outstanding load per entry. Decode stalls on pend_mask, so a second issue to a pending e never occurs.
- Starvation counter:
  - Increments while full && no drain this cycle; resets to 0 on any drain.
  - stall_req = (count ≥ STARVE_LIMIT), registered.
  - Deasserts the cycle after the first drain.
  - The counter saturates and does not wrap.
- Reset: FIFO empty, ld_ready=1, pend_mask=0, all kill bits 0, counter 0, stall_req=0, all rf_wen*=0. Reset mid-operation discards buffered loads without writing them.
- Width rules: FIFO pointers are log2(LD_DEPTH)+1 bits, and full/empty is taken from the MSB compare.

Decomposition:
- Shared package constants: RF_ENTRIES=24, RF_BANK1_BASE=16, the entry-index function, and the writeback record type {dst[3:0], bank, data[31:0]}.
- One sub-module, rf_wb_fifo: a parameterised synchronous FIFO with push/pop/full/empty/head.
- The arbiter, scoreboard and starvation logic stay in rf_wb_arb.

Test Plan:
- Pipe passthrough: p0 R3=0x11, p1 R4=0x22, bank0, FIFO empty -> same cycle rf_wen0/1=1, dst 3/4, data match; pend_mask=0.
- Drain slot: issue ld R8 at t0; return 0xDEAD at t2 with p1 idle -> t3 port1 writes R8=0xDEAD; pend_mask[8] 1→0 after t3.
- Bank entry: issue ld R2 bank1; return at t2 with p0 busy, p1 busy t3, idle t4 -> rf_wen1 at t4 with dst2 bank1; bit 18 pending until then.
- WAW kill: issue ld R5; p0 writes R5=0x7 before the return; return 0x9 -> no rf_wen for 0x9; R5 holds 0x7; pend[5] clears.
- Starvation: LD_DEPTH=2 full, p0 and p1 busy 4 cycles -> stall_req=1 on the 5th cycle; drops the cycle after the first drain; ld_ready=0 while full.
- Reset: fill FIFO with 2 entries, assert rst one cycle -> next cycle ld_ready=1, pend_mask=0, no rf_wen from the discarded entries.
